pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 12: control-bit width carried per entry (WB/M/EX controls).
REQ-002 Parameter PAY_W, default 146: payload width (PC 18 + ALUOp 4 + shamt 5 + 3x32 data + 3x5 register IDs + 8 spare).
REQ-003 Parameter FLUSH_MODE, default 0: 0 = flush zeroes control only and holds payload; 1 = flush zeroes control and payload.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 clk  in  1  single clock; all state updates on the falling edge, matching the pipeline registers.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  discard all held entries and any same-edge input.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage accepts an entry on this edge.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 in_pay  in  PAY_W  upstream payload.
REQ-012 out_valid  out  1  downstream entry present.
REQ-013 out_ready  in  1  downstream consumes on this edge.
REQ-014 out_ctrl  out  CTRL_W  head-entry control, forced to 0 when out_valid=0.
REQ-015 out_pay  out  PAY_W  head-entry payload.
REQ-016 occupancy  out  2  entries held (0..2).
REQ-017 stall_cnt  out  CNT_W  count of edges with out_valid=1 and out_ready=0, saturating.

Function
REQ-018 Accept = in_valid & in_ready; consume = out_valid & out_ready; both evaluated at the falling edge.
REQ-019 Storage SHALL be two entries: head (drives outputs) and skid.
REQ-020 State SHALL be EMPTY (occ 0), ONE (occ 1) or FULL (occ 2); occupancy reflects state directly.
REQ-021 in_ready SHALL be a pure decode of the state register: 1 in EMPTY/ONE, 0 in FULL; no combinational path from out_ready.
REQ-022 out_valid SHALL be 1 in ONE/FULL, 0 in EMPTY.
REQ-023 EMPTY: accept -> head<=input, ONE; else remain.
REQ-024 ONE: accept & consume -> head<=input, ONE; accept only -> skid<=input, FULL; consume only -> EMPTY; neither -> hold.
REQ-025 FULL: consume -> head<=skid, ONE; else hold; no accept is possible.
REQ-026 Latency SHALL be one falling edge from accept in EMPTY to out_valid=1; sustained throughput one entry per edge when out_ready=1.
REQ-027 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-028 flush=1 SHALL dominate: next state EMPTY, head/skid control zeroed, payload zeroed only if FLUSH_MODE=1, same-edge input discarded, same-edge consume irrelevant.
REQ-029 Head/skid contents SHALL hold unchanged while no transition writes them.
REQ-030 stall_cnt SHALL increment on each edge with out_valid=1 & out_ready=0, saturate at all-ones, and SHALL NOT be cleared by flush.

Reset
REQ-031 rst=1 SHALL asynchronously force state EMPTY, head/skid control and payload to 0, stall_cnt to 0.
REQ-032 Outputs during and after reset until first accept: in_ready=1, out_valid=0, out_ctrl=0, out_pay=0, occupancy=0.
REQ-033 Reset asserted mid-operation (ONE or FULL) SHALL discard all entries without emitting them.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and constants PC_W=18, DATA_W=32, REG_ID_W=5.
REQ-035 The saturating counter SHALL be a sub-module sat_cnt (parameter CNT_W; inputs clk, rst, inc; output count).

Verification
REQ-036 Reset: rst=1 while FULL -> immediately occupancy=0, out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1.
REQ-037 Streaming: out_ready=1, inputs pay=1..8 on 8 consecutive edges -> out_pay 1..8 on consecutive edges, occupancy never exceeds 1.
REQ-038 Backpressure: out_ready=0, send pay=0xA then 0xB -> occupancy=2, in_ready=0; out_ready=1 two edges -> 0xA then 0xB, in_ready=1 after first.
REQ-039 Flush in FULL with in_valid=1 (pay=0xC), FLUSH_MODE=0 -> next edge occupancy=0, out_ctrl=0, 0xC never emitted.
REQ-040 Stall counter: CNT_W=4, out_valid=1, out_ready=0 for 20 edges -> stall_cnt=15 held; flush -> stall_cnt remains 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage.
// Holds the stage state encoding, the field widths that make up the default
// payload, and a helper that maps a state to its entry count.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int PC_W     = 18;
    localparam int DATA_W   = 32;
    localparam int REG_ID_W = 5;
    localparam int ALUOP_W  = 4;
    localparam int SHAMT_W  = 5;
    localparam int SPARE_W  = 8;

    // PC + ALUOp + shamt + three data words + three register IDs + spare bits
    localparam int PAY_W_DEFAULT = PC_W + ALUOP_W + SHAMT_W + 3 * DATA_W
                                 + 3 * REG_ID_W + SPARE_W;

    function automatic logic [1:0] occupancy_of(input state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter, updated on the falling edge like the pipeline.
// Ports:
//   clk   - clock (state changes on falling edge)
//   rst   - asynchronous active-high reset, clears count
//   inc   - count one on this edge
//   count - current value, sticks at all-ones
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid buffer for a pipeline stage boundary (head + skid).
// in_ready decodes only the registered state, so there is no combinational
// path from out_ready back to the upstream stage.
// Ports:
//   clk, rst           - falling-edge clock, async active-high reset
//   flush              - drop all held entries and any same-edge input
//   in_valid/in_ready  - upstream handshake; in_ctrl/in_pay upstream entry
//   out_valid/out_ready- downstream handshake; out_ctrl/out_pay head entry
//   occupancy          - entries held (0..2)
//   stall_cnt          - saturating count of edges with out_valid & !out_ready
//
// state | meaning
// EMPTY | no entries held, outputs idle
// ONE   | head holds the only entry
// FULL  | head holds oldest entry, skid holds the next; upstream blocked
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 12,
    parameter int PAY_W      = PAY_W_DEFAULT,
    parameter int FLUSH_MODE = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PAY_W-1:0]  in_pay,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PAY_W-1:0]  out_pay,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state;
    state_t            state_next;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [PAY_W-1:0]  head_pay;
    logic [PAY_W-1:0]  skid_pay;
    logic              accept;
    logic              consume;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // State register
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state_next = ONE;
                end
                ONE: begin
                    if (accept && !consume) begin
                        state_next = FULL;
                    end else if (!accept && consume) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) state_next = ONE;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign occupancy = occupancy_of(state);
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign out_pay   = head_pay;

    // Entry storage; registers only change when a transition writes them.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            head_ctrl <= '0;
            skid_ctrl <= '0;
            head_pay  <= '0;
            skid_pay  <= '0;
        end else if (flush) begin
            head_ctrl <= '0;
            skid_ctrl <= '0;
            // Payload is don't-care once control is zero; holding it saves
            // toggling the wide datapath unless the caller asks for scrubbing.
            if (FLUSH_MODE != 0) begin
                head_pay <= '0;
                skid_pay <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_ctrl <= in_ctrl;
                        head_pay  <= in_pay;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_ctrl <= in_ctrl;
                        head_pay  <= in_pay;
                    end else if (accept) begin
                        skid_ctrl <= in_ctrl;
                        skid_pay  <= in_pay;
                    end
                end
                FULL: begin
                    if (consume) begin
                        head_ctrl <= skid_ctrl;
                        head_pay  <= skid_pay;
                    end
                end
                default: begin
                    head_ctrl <= '0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int CTRL_W = 12;
    localparam int PAY_W  = 146;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [PAY_W-1:0]  p;
    } entry_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PAY_W-1:0]  in_pay;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PAY_W-1:0]  out_pay;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int     errors = 0;
    int     checks = 0;
    entry_t q[$];
    int     stall_m = 0;

    pipe_stage_skid #(
        .CTRL_W     (CTRL_W),
        .PAY_W      (PAY_W),
        .FLUSH_MODE (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_pay    (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pay   (out_pay),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_all(input string tag);
        chk({tag, ":occupancy"}, 160'(occupancy), 160'(q.size()));
        chk({tag, ":in_ready"},  160'(in_ready),  160'(q.size() < 2));
        chk({tag, ":out_valid"}, 160'(out_valid), 160'(q.size() > 0));
        chk({tag, ":out_ctrl"},  160'(out_ctrl),  (q.size() > 0) ? 160'(q[0].c) : 160'(0));
        if (q.size() > 0)
            chk({tag, ":out_pay"}, 160'(out_pay), 160'(q[0].p));
        chk({tag, ":stall_cnt"}, 160'(stall_cnt), 160'(stall_m));
    endtask

    // One falling-edge step: drive after the rising edge, update the model
    // at the falling edge, then compare.
    task automatic step(input logic iv, input logic [CTRL_W-1:0] ic,
                        input logic [PAY_W-1:0] ip, input logic ordy,
                        input logic fl, input string tag);
        int sz;
        entry_t e;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_ctrl   = ic;
        in_pay    = ip;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        sz = q.size();
        if (sz > 0 && !ordy && stall_m < CNT_MAX) stall_m++;
        if (fl) begin
            q.delete();
        end else begin
            if (sz > 0 && ordy) void'(q.pop_front());
            if (iv && sz < 2) begin
                e.c = ic;
                e.p = ip;
                q.push_back(e);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        stall_m = 0;
        chk({tag, ":occupancy"}, 160'(occupancy), 160'(0));
        chk({tag, ":out_valid"}, 160'(out_valid), 160'(0));
        chk({tag, ":out_ctrl"},  160'(out_ctrl),  160'(0));
        chk({tag, ":out_pay"},   160'(out_pay),   160'(0));
        chk({tag, ":stall_cnt"}, 160'(stall_cnt), 160'(0));
        chk({tag, ":in_ready"},  160'(in_ready),  160'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [PAY_W-1:0] rand_pay();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[PAY_W-1:0];
    endfunction

    initial begin
        logic [PAY_W-1:0] zp;
        zp        = '0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_pay    = '0;
        out_ready = 1'b0;

        // Reset state while rst held
        #2;
        chk("rst:occupancy", 160'(occupancy), 160'(0));
        chk("rst:in_ready",  160'(in_ready),  160'(1));
        chk("rst:out_valid", 160'(out_valid), 160'(0));
        chk("rst:out_ctrl",  160'(out_ctrl),  160'(0));
        chk("rst:out_pay",   160'(out_pay),   160'(0));
        chk("rst:stall_cnt", 160'(stall_cnt), 160'(0));
        #10;
        rst = 1'b0;
        step(1'b0, '0, zp, 1'b0, 1'b0, "idle");
        chk("idle:out_pay", 160'(out_pay), 160'(0));

        // Streaming: one entry per edge, never more than one held
        for (int i = 1; i <= 8; i++)
            step(1'b1, CTRL_W'(12'h100 + i), PAY_W'(i), 1'b1, 1'b0, "stream");
        step(1'b0, '0, zp, 1'b1, 1'b0, "stream_drain");
        step(1'b0, '0, zp, 1'b1, 1'b0, "stream_idle");

        // Backpressure: fill both entries, then drain in order
        step(1'b1, 12'h0AA, PAY_W'(8'hA), 1'b0, 1'b0, "bp_a");
        step(1'b1, 12'h0BB, PAY_W'(8'hB), 1'b0, 1'b0, "bp_b");
        chk("bp_full_occ", 160'(occupancy), 160'(2));
        step(1'b1, 12'h0DD, PAY_W'(8'hD), 1'b1, 1'b0, "bp_drain1");
        chk("bp_after_first_ready", 160'(in_ready), 160'(1));
        step(1'b0, '0, zp, 1'b1, 1'b0, "bp_drain2");
        step(1'b0, '0, zp, 1'b1, 1'b0, "bp_drain3");

        // Flush while FULL with a same-edge input
        step(1'b1, 12'h011, PAY_W'(8'h11), 1'b0, 1'b0, "fl_fill1");
        step(1'b1, 12'h022, PAY_W'(8'h22), 1'b0, 1'b0, "fl_fill2");
        step(1'b1, 12'h0CC, PAY_W'(8'hC), 1'b1, 1'b1, "fl_full");
        step(1'b0, '0, zp, 1'b1, 1'b0, "fl_after1");
        step(1'b0, '0, zp, 1'b1, 1'b0, "fl_after2");
        // Flush while ONE: input on the flush edge must vanish
        step(1'b1, 12'h033, PAY_W'(8'h33), 1'b0, 1'b0, "fl_one_fill");
        step(1'b1, 12'h0CC, PAY_W'(8'hC), 1'b1, 1'b1, "fl_one");
        step(1'b0, '0, zp, 1'b1, 1'b0, "fl_one_after");

        // Stall counter saturates and survives flush
        reset_mid_cycle("rst_pre_stall");
        step(1'b1, 12'h055, PAY_W'(8'h55), 1'b0, 1'b0, "stall_load");
        for (int i = 0; i < 20; i++)
            step(1'b0, '0, zp, 1'b0, 1'b0, "stall");
        chk("stall_sat", 160'(stall_cnt), 160'(CNT_MAX));
        step(1'b0, '0, zp, 1'b0, 1'b1, "stall_flush");
        chk("stall_after_flush", 160'(stall_cnt), 160'(CNT_MAX));

        // Reset asserted while FULL
        step(1'b1, 12'h066, PAY_W'(8'h66), 1'b0, 1'b0, "rf_fill1");
        step(1'b1, 12'h077, PAY_W'(8'h77), 1'b0, 1'b0, "rf_fill2");
        reset_mid_cycle("rst_full");
        step(1'b0, '0, zp, 1'b1, 1'b0, "rf_after");

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom), rand_pay(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
